// File: rtl/comm_packet_buffer.sv
// comm_packet_buffer
// Assembles the flagged bit stream from comm_receiver into bytes, stages each packet in a byte
// RAM and commits it only when decoding ends cleanly. Failed, runt, misaligned or overflowing
// packets are rolled back. Committed payloads (trailer stripped) stream out on valid/ready.
//
// Ports:
//   inclk, reset           clock and synchronous active-high reset
//   new_bit_clk, new_bit   data bit strobe (rising edge) and bit value, LSB first
//   decoding               high while a frame is being decoded; falling edge ends a packet
//   start_byte_detected    rising edge (with decoding high) starts a packet
//   decoding_failed        failure flag, valid on the cycle decoding is first seen low
//   m_data/m_valid/m_last  payload byte stream; m_last marks the final byte of a packet
//   m_ready                consumer accept
//   overflow               one-cycle pulse when a packet is dropped for lack of RAM space
//   pkt_ok_cnt             committed packets, saturating
//   pkt_drop_cnt           dropped packets, saturating
//   busy                   write side not idle
module comm_packet_buffer #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned LEN_FIFO_W    = 2,
  parameter int unsigned TRAILER_BYTES = 5
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        new_bit_clk,
  input  logic        new_bit,
  input  logic        decoding,
  input  logic        start_byte_detected,
  input  logic        decoding_failed,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        overflow,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] pkt_drop_cnt,
  output logic        busy
);

  typedef logic [ADDR_W:0]     ptr_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [LEN_FIFO_W:0] lptr_t;

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned LenDepth = 2 ** LEN_FIFO_W;
  localparam ptr_t  DepthV    = {1'b1, {ADDR_W{1'b0}}};
  localparam lptr_t LenDepthV = {1'b1, {LEN_FIFO_W{1'b0}}};
  localparam ptr_t  TrailerV  = ptr_t'(TRAILER_BYTES);

  typedef enum logic [1:0] {StIdle, StCollect, StCommit, StDiscard} state_e;

  state_e      state_q, state_d;
  logic        nbc_q, dec_q, start_q;
  logic [6:0]  shreg_q, shreg_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  ptr_t        pkt_bytes_q, pkt_bytes_d;
  logic        ovf_flag_q, ovf_flag_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        commit_ptr_q, commit_ptr_d;
  ptr_t        rd_ptr_q;
  logic [15:0] ok_cnt_q, drop_cnt_q;
  lptr_t       len_wp_q, len_rp_q;
  ptr_t        remaining_q;
  logic        m_valid_q;
  logic [7:0]  m_data_q;

  logic [7:0] mem [Depth];
  ptr_t       len_mem [LenDepth];

  logic       bit_rise, dec_fall, start_rise;
  logic [7:0] byte_asm;
  ptr_t       used, commit_len, commit_target, len_head;
  lptr_t      len_count;
  logic       len_full, len_empty;
  logic       mem_we, len_push, ok_inc, drop_inc;
  logic       fire, last_fire, load;
  addr_t      rd_addr;

  assign bit_rise   = new_bit_clk & ~nbc_q;
  assign dec_fall   = ~decoding & dec_q;
  assign start_rise = start_byte_detected & ~start_q;

  assign byte_asm      = {new_bit, shreg_q};
  assign used          = wr_ptr_q - rd_ptr_q;
  assign len_count     = len_wp_q - len_rp_q;
  assign len_full      = (len_count == LenDepthV);
  assign len_empty     = (len_count == '0);
  assign commit_len    = pkt_bytes_q - TrailerV;
  assign commit_target = commit_ptr_q + commit_len;

  // Write-side FSM: next state and datapath updates.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    pkt_bytes_d  = pkt_bytes_q;
    ovf_flag_d   = ovf_flag_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    len_push     = 1'b0;
    ok_inc       = 1'b0;
    drop_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_rise && decoding) begin
          state_d     = StCollect;
          bitcnt_d    = '0;
          pkt_bytes_d = '0;
          ovf_flag_d  = 1'b0;
          wr_ptr_d    = commit_ptr_q;
        end
      end
      StCollect: begin
        if (bit_rise) begin
          shreg_d  = byte_asm[7:1];
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (used < DepthV) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + ptr_t'(1);
              if (pkt_bytes_q != '1) pkt_bytes_d = pkt_bytes_q + ptr_t'(1);
            end else begin
              ovf_flag_d = 1'b1;
            end
          end
        end
        // Decision uses the post-capture values so a same-cycle bit is counted.
        if (dec_fall) begin
          if (!decoding_failed && !ovf_flag_d && (bitcnt_d == 3'd0) &&
              (pkt_bytes_d > TrailerV) && !len_full) begin
            state_d = StCommit;
          end else begin
            state_d = StDiscard;
          end
        end
      end
      StCommit: begin
        len_push     = 1'b1;
        ok_inc       = 1'b1;
        // Trailer bytes are abandoned: the next packet overwrites them.
        commit_ptr_d = commit_target;
        wr_ptr_d     = commit_target;
        state_d      = StIdle;
      end
      StDiscard: begin
        drop_inc = 1'b1;
        wr_ptr_d = commit_ptr_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge inclk) begin
    if (reset) begin
      state_q      <= StIdle;
      nbc_q        <= 1'b0;
      dec_q        <= 1'b0;
      start_q      <= 1'b1;  // ignore a packet already in flight at reset release
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      pkt_bytes_q  <= '0;
      ovf_flag_q   <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      ok_cnt_q     <= '0;
      drop_cnt_q   <= '0;
      len_wp_q     <= '0;
    end else begin
      state_q      <= state_d;
      nbc_q        <= new_bit_clk;
      dec_q        <= decoding;
      start_q      <= start_byte_detected;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      pkt_bytes_q  <= pkt_bytes_d;
      ovf_flag_q   <= ovf_flag_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      if (ok_inc && (ok_cnt_q != 16'hFFFF)) ok_cnt_q <= ok_cnt_q + 16'd1;
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (len_push) len_wp_q <= len_wp_q + lptr_t'(1);
    end
  end

  // Storage arrays carry no reset; pointers define what is valid.
  always_ff @(posedge inclk) begin
    if (mem_we) mem[wr_ptr_q[ADDR_W-1:0]] <= byte_asm;
    if (len_push) len_mem[len_wp_q[LEN_FIFO_W-1:0]] <= commit_len;
  end

  // Read side. rd_ptr addresses the byte on m_data while m_valid is high, otherwise the next
  // byte to fetch. m_data is the registered RAM read; its address looks one byte ahead on a
  // handshake so back-to-back transfers need no bubble.
  assign fire      = m_valid_q & m_ready;
  assign last_fire = fire & (remaining_q == ptr_t'(1));
  assign load      = (~m_valid_q | last_fire) & ~len_empty;
  assign rd_addr   = fire ? rd_ptr_q[ADDR_W-1:0] + addr_t'(1) : rd_ptr_q[ADDR_W-1:0];
  assign len_head  = len_mem[len_rp_q[LEN_FIFO_W-1:0]];

  always_ff @(posedge inclk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      len_rp_q    <= '0;
      remaining_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      if (fire) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      if (load) begin
        len_rp_q    <= len_rp_q + lptr_t'(1);
        remaining_q <= len_head;
        m_valid_q   <= 1'b1;
        m_data_q    <= mem[rd_addr];
      end else if (fire) begin
        remaining_q <= remaining_q - ptr_t'(1);
        if (last_fire) m_valid_q <= 1'b0;
        else           m_data_q  <= mem[rd_addr];
      end
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_valid_q & (remaining_q == ptr_t'(1));
  assign overflow     = (state_q == StDiscard) & ovf_flag_q;
  assign pkt_ok_cnt   = ok_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_comm_packet_buffer.sv
// Bench for comm_packet_buffer: a default instance (dut_a) and a 16-byte RAM instance (dut_b)
// share one stimulus driver selected by sel. Expected output bytes are queued per instance and
// checked by a monitor on each handshake.
module tb_comm_packet_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic stim_nbc, stim_nb, stim_dec, stim_start, stim_failed;
  logic sel;
  logic m_ready;
  bit   toggle = 1'b0;
  bit   ready_lvl = 1'b0;

  logic a_nbc, a_nb, a_dec, a_start, a_failed;
  logic b_nbc, b_nb, b_dec, b_start, b_failed;
  logic [7:0]  a_data, b_data;
  logic        a_valid, a_last, a_ovf, a_busy, b_valid, b_last, b_ovf, b_busy;
  logic [15:0] a_ok, a_drop, b_ok, b_drop;

  assign a_nbc    = sel ? 1'b0 : stim_nbc;
  assign a_nb     = sel ? 1'b0 : stim_nb;
  assign a_dec    = sel ? 1'b0 : stim_dec;
  assign a_start  = sel ? 1'b0 : stim_start;
  assign a_failed = sel ? 1'b0 : stim_failed;
  assign b_nbc    = sel ? stim_nbc : 1'b0;
  assign b_nb     = sel ? stim_nb : 1'b0;
  assign b_dec    = sel ? stim_dec : 1'b0;
  assign b_start  = sel ? stim_start : 1'b0;
  assign b_failed = sel ? stim_failed : 1'b0;

  comm_packet_buffer dut_a (
    .inclk(clk), .reset(reset), .new_bit_clk(a_nbc), .new_bit(a_nb), .decoding(a_dec),
    .start_byte_detected(a_start), .decoding_failed(a_failed), .m_data(a_data),
    .m_valid(a_valid), .m_last(a_last), .m_ready(m_ready), .overflow(a_ovf),
    .pkt_ok_cnt(a_ok), .pkt_drop_cnt(a_drop), .busy(a_busy)
  );

  comm_packet_buffer #(.ADDR_W(4)) dut_b (
    .inclk(clk), .reset(reset), .new_bit_clk(b_nbc), .new_bit(b_nb), .decoding(b_dec),
    .start_byte_detected(b_start), .decoding_failed(b_failed), .m_data(b_data),
    .m_valid(b_valid), .m_last(b_last), .m_ready(m_ready), .overflow(b_ovf),
    .pkt_ok_cnt(b_ok), .pkt_drop_cnt(b_drop), .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;
  int ovf_a = 0;
  int ovf_b = 0;
  logic [8:0] exp_a [$];
  logic [8:0] exp_b [$];
  logic [7:0] pkt [$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // m_ready driver: fixed level or 1010... toggling.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (toggle) m_ready = ~m_ready;
      else        m_ready = ready_lvl;
    end
  end

  initial forever begin
    @(negedge clk);
    if (a_ovf === 1'b1) ovf_a++;
    if (b_ovf === 1'b1) ovf_b++;
  end

  // Monitor for dut_a: scoreboard pop on handshake, hold check after a stall.
  initial begin
    logic       stall = 1'b0;
    logic [7:0] sdata = '0;
    logic       slast = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("a_hold_valid", a_valid, 1);
          chk("a_hold_data", a_data, sdata);
          chk("a_hold_last", a_last, slast);
        end
        if (a_valid && m_ready) begin
          if (exp_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected: got byte %02h expected no output", a_data);
          end else begin
            e = exp_a.pop_front();
            chk("a_data", a_data, e[7:0]);
            chk("a_last", a_last, e[8]);
          end
        end
        stall = a_valid && !m_ready;
        sdata = a_data;
        slast = a_last;
      end
    end
  end

  // Monitor for dut_b.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!reset && b_valid && m_ready) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected: got byte %02h expected no output", b_data);
        end else begin
          e = exp_b.pop_front();
          chk("b_data", b_data, e[7:0]);
          chk("b_last", b_last, e[8]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add_trailer();
    pkt.push_back(8'h11);
    pkt.push_back(8'h22);
    pkt.push_back(8'h33);
    pkt.push_back(8'h44);
    pkt.push_back(8'h7E);
  endtask

  task automatic start_pkt();
    stim_dec   = 1'b1;
    stim_start = 1'b1;
    cycle();
  endtask

  task automatic send_bits(input int from, input int to);
    logic [7:0] bv;
    for (int i = from; i < to; i++) begin
      bv       = pkt[i / 8];
      stim_nb  = bv[i % 8];
      stim_nbc = 1'b1;
      cycle();
      stim_nbc = 1'b0;
      cycle();
    end
  endtask

  task automatic end_pkt(input logic failed);
    stim_dec    = 1'b0;
    stim_start  = 1'b0;
    stim_failed = failed;
    cycle();
    stim_failed = 1'b0;
  endtask

  task automatic send_pkt(input int nbits, input logic failed);
    start_pkt();
    send_bits(0, nbits);
    end_pkt(failed);
    repeat (4) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    sel = 1'b0;
    stim_nbc = 1'b0; stim_nb = 1'b0; stim_dec = 1'b0; stim_start = 1'b0; stim_failed = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", a_valid, 0);
    chk("rst_last", a_last, 0);
    chk("rst_data", a_data, 0);
    chk("rst_ok", a_ok, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_b_valid", b_valid, 0);

    // Good packet, ready held high, latency and back-to-back delivery.
    ready_lvl = 1'b1;
    cycle();
    pkt = '{8'hA5, 8'h3C, 8'hFF};
    add_trailer();
    exp_a.push_back({1'b0, 8'hA5});
    exp_a.push_back({1'b0, 8'h3C});
    exp_a.push_back({1'b1, 8'hFF});
    start_pkt();
    send_bits(0, 64);
    end_pkt(1'b0);
    n = 0;
    @(negedge clk);
    while (a_ok != 16'd1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t1_ok_cnt", a_ok, 1);
    chk("t1_valid_commit_plus1", a_valid, 0);
    @(negedge clk);
    chk("t1_valid_commit_plus2", a_valid, 1);
    @(negedge clk);
    chk("t1_valid_byte2", a_valid, 1);
    @(negedge clk);
    chk("t1_valid_byte3", a_valid, 1);
    chk("t1_last_byte3", a_last, 1);
    @(negedge clk);
    chk("t1_valid_after", a_valid, 0);
    cycle();
    do_reset();

    // Failed decode rolls back.
    send_pkt(64, 1'b1);
    chk("t2_drop", a_drop, 1);
    chk("t2_ok", a_ok, 0);
    chk("t2_valid", a_valid, 0);
    chk("t2_wr_ptr", dut_a.wr_ptr_q, 0);
    chk("t2_commit_ptr", dut_a.commit_ptr_q, 0);

    // Two packets, ready toggling.
    toggle = 1'b1;
    pkt = '{8'h01, 8'h02};
    add_trailer();
    exp_a.push_back({1'b0, 8'h01});
    exp_a.push_back({1'b1, 8'h02});
    send_pkt(56, 1'b0);
    pkt = '{8'h03, 8'h04, 8'h05};
    add_trailer();
    exp_a.push_back({1'b0, 8'h03});
    exp_a.push_back({1'b0, 8'h04});
    exp_a.push_back({1'b1, 8'h05});
    send_pkt(64, 1'b0);
    repeat (20) cycle();
    toggle = 1'b0;
    ready_lvl = 1'b1;
    repeat (2) cycle();
    chk("t3_ok", a_ok, 2);
    chk("t3_drained", exp_a.size(), 0);

    // Overflow on the 16-byte instance, then a small packet.
    sel = 1'b1;
    cycle();
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(8'(i + 8'h40));
    send_pkt(160, 1'b0);
    chk("t4_ovf_pulses", ovf_b, 1);
    chk("t4_drop", b_drop, 1);
    chk("t4_ok0", b_ok, 0);
    pkt = '{8'h5A};
    add_trailer();
    exp_b.push_back({1'b1, 8'h5A});
    send_pkt(48, 1'b0);
    repeat (6) cycle();
    chk("t4_ok1", b_ok, 1);
    chk("t4_drained", exp_b.size(), 0);
    sel = 1'b0;
    cycle();
    do_reset();

    // Runt and misaligned packets.
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_pkt(40, 1'b0);
    send_pkt(37, 1'b0);
    chk("t5_drop", a_drop, 2);
    chk("t5_ok", a_ok, 0);
    chk("t5_valid", a_valid, 0);

    // Reset mid-collect with an unread committed packet.
    ready_lvl = 1'b0;
    do_reset();
    pkt = '{8'hC1, 8'hC2};
    add_trailer();
    send_pkt(56, 1'b0);
    chk("t6_ok_pre", a_ok, 1);
    chk("t6_valid_pre", a_valid, 1);
    pkt = '{8'hD1, 8'hD2, 8'hD3};
    add_trailer();
    start_pkt();
    send_bits(0, 20);
    reset = 1'b1;
    cycle();
    @(negedge clk);
    chk("t6_rst_valid", a_valid, 0);
    chk("t6_rst_ok", a_ok, 0);
    chk("t6_rst_drop", a_drop, 0);
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_last", a_last, 0);
    chk("t6_rst_data", a_data, 0);
    reset = 1'b0;
    ready_lvl = 1'b1;
    cycle();
    send_bits(20, 64);
    end_pkt(1'b0);
    repeat (6) cycle();
    chk("t6_inflight_ok", a_ok, 0);
    chk("t6_inflight_drop", a_drop, 0);
    chk("t6_inflight_valid", a_valid, 0);
    pkt = '{8'hE1, 8'hE2, 8'hE3};
    add_trailer();
    exp_a.push_back({1'b0, 8'hE1});
    exp_a.push_back({1'b0, 8'hE2});
    exp_a.push_back({1'b1, 8'hE3});
    send_pkt(64, 1'b0);
    repeat (8) cycle();
    chk("t6_ok_after", a_ok, 1);

    chk("end_exp_a_empty", exp_a.size(), 0);
    chk("end_exp_b_empty", exp_b.size(), 0);
    chk("end_no_ovf_a", ovf_a, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
